rr_arb_4: RTL

RR_ARB_4 -- requirements
Module: rr_arb_4

---
 rtl/rr_arb_4.sv | 93 +++++++++
 1 files changed

// File: rtl/rr_arb_4.sv
// Four-channel arbiter with a registered output stage; round-robin by default,
// fixed priority (channel 0 highest) when RR_ARB_4_FIXED_PRIO_EN is defined.
module rr_arb_4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [3:0]       req_valid,
  output logic [3:0]       req_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel
);

  // Handshake: a channel or the output transfers on a rising edge where its
  // valid and ready are both 1; the output register reloads whenever it is
  // empty or being drained (load), so req_ready never looks at data inputs.
  logic             load;
  logic             has_win;
  logic [1:0]       win;
  logic [WIDTH-1:0] win_data;

`ifndef RR_ARB_4_FIXED_PRIO_EN
  logic [1:0] ptr;
  logic [1:0] idx;
`endif

  assign load    = ~out_valid | out_ready;
  assign has_win = |req_valid;

  // Scan from farthest to nearest so the nearest set bit is assigned last.
  always_comb begin
    win = 2'd0;
`ifdef RR_ARB_4_FIXED_PRIO_EN
    for (int i = 3; i >= 0; i--) begin
      if (req_valid[i]) win = 2'(i);
    end
`else
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req_valid[idx]) win = idx;
    end
`endif
  end

  always_comb begin
    req_ready = 4'b0000;
    if (load && has_win) req_ready = 4'b0001 << win;
  end

  always_comb begin
    case (win)
      2'd0:    win_data = d0;
      2'd1:    win_data = d1;
      2'd2:    win_data = d2;
      default: win_data = d3;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 2'd0;
    end else if (load) begin
      if (has_win) begin
        out_valid <= 1'b1;
        out_data  <= win_data;
        out_sel   <= win;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifndef RR_ARB_4_FIXED_PRIO_EN
  // Pointer moves past the winner only when an input actually transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 2'd0;
    end else if (load && has_win) begin
      ptr <= win + 2'd1;
    end
  end
`endif

endmodule
